// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed seven-segment driver: snapshots TENS/ONES once per frame and
// scans them onto a shared active-low segment bus with optional dead-time gaps.
//
// state      | meaning
// RESET_IDLE | after reset, display dark; leaves on the first clock edge
// ONES_ON    | ones digit driven (entered with a capture of TENS/ONES/BLANK_LZ)
// GAP_A      | all digits off between ones and tens
// TENS_ON    | tens digit driven, blanked if leading-zero blanking applies
// GAP_B      | all digits off between tens and the next frame
module bcd_7seg_scan #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  input  logic       BLANK_LZ,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       FRAME_START
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ONES  = 3'd1;
  localparam logic [2:0] S_GAP_A = 3'd2;
  localparam logic [2:0] S_TENS  = 3'd3;
  localparam logic [2:0] S_GAP_B = 3'd4;

  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  logic [2:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0]       tens_q, ones_q, tens_n, ones_n;
  logic             blank_q, blank_n;
  logic             capture;
  logic [6:0]       seg_n;
  logic [1:0]       an_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    case (state)
      S_IDLE: begin
        nxt_state = S_ONES;
        nxt_cnt   = '0;
      end
      S_ONES: if (cnt == DIG_LAST) begin
        nxt_state = HAS_GAP ? S_GAP_A : S_TENS;
        nxt_cnt   = '0;
      end
      S_GAP_A: if (cnt == GAP_LAST) begin
        nxt_state = S_TENS;
        nxt_cnt   = '0;
      end
      S_TENS: if (cnt == DIG_LAST) begin
        nxt_state = HAS_GAP ? S_GAP_B : S_ONES;
        nxt_cnt   = '0;
      end
      S_GAP_B: if (cnt == GAP_LAST) begin
        nxt_state = S_ONES;
        nxt_cnt   = '0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so the capture edge
  // already shows the freshly sampled ones digit.
  always_comb begin
    capture = (nxt_state == S_ONES) && (state != S_ONES);
    tens_n  = capture ? TENS : tens_q;
    ones_n  = capture ? ONES : ones_q;
    blank_n = capture ? BLANK_LZ : blank_q;
    an_n    = 2'b11;
    seg_n   = 7'h7F;
    case (nxt_state)
      S_ONES: begin
        an_n  = 2'b10;
        seg_n = decode(ones_n);
      end
      S_TENS: begin
        an_n  = 2'b01;
        seg_n = (blank_n && tens_n == 4'd0) ? 7'h7F : decode(tens_n);
      end
      default: begin
        an_n  = 2'b11;
        seg_n = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      blank_q     <= 1'b0;
      AN          <= 2'b11;
      SEG         <= 7'h7F;
      FRAME_START <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      tens_q      <= tens_n;
      ones_q      <= ones_n;
      blank_q     <= blank_n;
      AN          <= an_n;
      SEG         <= seg_n;
      FRAME_START <= capture;
    end
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Two-digit multiplexed seven-segment display driver, directly downstream of the binary-to-BCD converter in the counter/BCD path. Takes the converter's TENS/ONES nibbles, snapshots them once per refresh frame so a frame never tears, and time-multiplexes both digits onto one shared active-low segment bus. Optional leading-zero blanking and a dead-time gap between digits suppress ghosting.

## Interface
- DIGIT_CYCLES, 50000, clock cycles each digit is driven (minimum 1)
- GAP_CYCLES, 4, all-off cycles between digits; 0 removes the gap states
- CNT_W, 16, width of the internal cycle counter; must hold max(DIGIT_CYCLES, GAP_CYCLES)-1

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- TENS  input  4  BCD tens digit from the converter
- ONES  input  4  BCD ones digit from the converter
- BLANK_LZ  input  1  1 = blank the tens digit when its captured value is 0
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low
- AN  output  2  digit enables {tens,ones}, active-low
- FRAME_START  output  1  one-cycle pulse on the cycle TENS/ONES are captured

## Operation
- States: RESET_IDLE → ONES_ON → GAP_A → TENS_ON → GAP_B → ONES_ON …
- GAP_A and GAP_B are skipped entirely when GAP_CYCLES = 0.
- Capture: on every entry to ONES_ON, including the first after reset, TENS, ONES and BLANK_LZ are latched into internal registers. The display reflects only the latched values until the next capture.
- ONES_ON: AN = 2'b10, SEG = decode(ones_q).
- TENS_ON: AN = 2'b01. SEG = 7'h7F if blank_q = 1 and tens_q = 0; otherwise SEG = decode(tens_q).
- GAP_A / GAP_B: AN = 2'b11, SEG = 7'h7F.
- Decode, active-low {g..a}:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
  - 10–15 (invalid BCD) → 0111111 (dash: g only)
- Cycle counter:
  - Counts 0 .. N-1 in each state, where N = DIGIT_CYCLES or GAP_CYCLES.
  - At N-1 it advances the state and clears to 0.
  - It never wraps within a state.

## Timing
- Reset (rst_n low, asynchronous):
  - AN = 2'b11, SEG = 7'h7F, FRAME_START = 0.
  - Counter cleared; latched digits cleared to 0; state = RESET_IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- First rising edge after rst_n rises (edge E1):
  - Capture occurs.
  - AN = 2'b10, SEG = decode(ONES sampled at E1), FRAME_START = 1.
- FRAME_START is high for exactly the one cycle following each capture edge; otherwise 0.
- Each ONES_ON / TENS_ON interval lasts exactly DIGIT_CYCLES cycles.
- Each gap lasts exactly GAP_CYCLES cycles.
- Frame period = 2·(DIGIT_CYCLES + GAP_CYCLES) cycles; FRAME_START pulses are exactly one frame apart.
- Input changes mid-frame have no visible effect until the next capture edge.
- An input change on the capture edge itself is taken, per normal setup/hold sampling.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). After release, operation restarts at E1 behaviour regardless of the prior state.
- AN never has both bits low; the transition between digits always passes through 2'b11 when GAP_CYCLES > 0.

## Test plan
- Reset/startup, DIGIT_CYCLES = 4, GAP_CYCLES = 2, TENS = 4, ONES = 2:
  - During reset: AN = 11, SEG = 7F.
  - After E1: FRAME_START pulse; AN = 10 / SEG = 0100100 for 4 cycles, then AN = 11 for 2 cycles, then AN = 01 / SEG = 0011001 for 4 cycles, then 2 gap cycles.
  - Next FRAME_START arrives 12 cycles after the first.
- Snapshot: change ONES from 2 to 7 two cycles into ONES_ON → SEG stays 0100100 until the next frame, then shows 1111000.
- Leading-zero blanking, TENS = 0, ONES = 5:
  - BLANK_LZ = 1 → TENS_ON has AN = 01, SEG = 7F.
  - BLANK_LZ = 0 → TENS_ON has SEG = 1000000.
- Invalid BCD: TENS = 4'hC, ONES = 4'hF → both digits show 0111111.
- No gap, GAP_CYCLES = 0, DIGIT_CYCLES = 3:
  - AN goes 10 directly to 01 with no 11 cycle between them.
  - Frame period is 6 cycles.
- Mid-frame reset: assert rst_n low during TENS_ON → AN = 11, SEG = 7F in the same cycle, with no clock edge required. After release, the first frame restarts in ONES_ON with a FRAME_START pulse.
